calc_operand_sequencer: RTL and testbench



---
 rtl/calc_operand_sequencer.sv | 118 +++++++++++
 tb/tb_calc_operand_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/calc_operand_sequencer.sv
// calc_operand_sequencer: captures two keypad digits as adder operands and
// registers the adder's sum/carry as a 5-bit result.  Rev 1.0
`default_nettype none

module calc_operand_sequencer (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [3:0] Key,
  input  logic       KeyVld,
  input  logic       Clr,
  input  logic [3:0] SumIn,
  input  logic       CryIn,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic [4:0] Res,
  output logic       ResVld,
  output logic       Err
);

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_ADD  = 2'd2,
    S_SHOW = 2'd3
  } state_t;

  state_t     state_q;
  logic       kprev_q;
  logic [3:0] a_q;
  logic [3:0] b_q;
  logic [4:0] res_q;
  logic       resvld_q;
  logic       err_q;

  logic       press;
  logic       key_ok;

  assign press  = KeyVld & ~kprev_q;
  assign key_ok = (Key <= 4'd9);

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q  <= S_A;
      kprev_q  <= 1'b1;
      a_q      <= 4'd0;
      b_q      <= 4'd0;
      res_q    <= 5'd0;
      resvld_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      // Edge detector keeps running through Clr so a held key is not re-seen.
      kprev_q <= KeyVld;
      if (Clr) begin
        state_q  <= S_A;
        a_q      <= 4'd0;
        b_q      <= 4'd0;
        res_q    <= 5'd0;
        resvld_q <= 1'b0;
        err_q    <= 1'b0;
      end else begin
        case (state_q)
          S_A: begin
            if (press) begin
              if (key_ok) begin
                a_q     <= Key;
                b_q     <= 4'd0;
                err_q   <= 1'b0;
                state_q <= S_B;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          S_B: begin
            if (press) begin
              if (key_ok) begin
                b_q     <= Key;
                err_q   <= 1'b0;
                state_q <= S_ADD;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          S_ADD: begin
            // Operands have been stable a full cycle; adder output is settled.
            res_q    <= {CryIn, SumIn};
            resvld_q <= 1'b1;
            state_q  <= S_SHOW;
          end
          S_SHOW: begin
            if (press) begin
              if (key_ok) begin
                a_q      <= Key;
                b_q      <= 4'd0;
                resvld_q <= 1'b0;
                err_q    <= 1'b0;
                state_q  <= S_B;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          default: state_q <= S_A;
        endcase
      end
    end
  end

  assign A      = a_q;
  assign B      = b_q;
  assign Res    = res_q;
  assign ResVld = resvld_q;
  assign Err    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_calc_operand_sequencer.sv
// Directed testbench for calc_operand_sequencer with a behavioural 4-bit adder.
`default_nettype none

module tb_calc_operand_sequencer;

  logic       Clk;
  logic       Rst;
  logic [3:0] Key;
  logic       KeyVld;
  logic       Clr;
  logic [3:0] SumIn;
  logic       CryIn;
  logic [3:0] A;
  logic [3:0] B;
  logic [4:0] Res;
  logic       ResVld;
  logic       Err;

  int n_checks = 0;
  int n_errors = 0;

  calc_operand_sequencer dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .Key    (Key),
    .KeyVld (KeyVld),
    .Clr    (Clr),
    .SumIn  (SumIn),
    .CryIn  (CryIn),
    .A      (A),
    .B      (B),
    .Res    (Res),
    .ResVld (ResVld),
    .Err    (Err)
  );

  // Downstream combinational adder
  assign {CryIn, SumIn} = {1'b0, A} + {1'b0, B};

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic key_down(input logic [3:0] k);
    Key    = k;
    KeyVld = 1'b1;
    tick();
  endtask

  task automatic key_up();
    KeyVld = 1'b0;
    tick();
  endtask

  task automatic press(input logic [3:0] k);
    key_down(k);
    key_up();
  endtask

  task automatic do_reset();
    Rst    = 1'b0;
    KeyVld = 1'b0;
    Clr    = 1'b0;
    tick();
    tick();
    Rst = 1'b1;
    tick();
  endtask

  initial begin
    Rst    = 1'b0;
    Key    = 4'd0;
    KeyVld = 1'b0;
    Clr    = 1'b0;
    do_reset();
    check("rst_A", A, 0);
    check("rst_B", B, 0);
    check("rst_Res", Res, 0);
    check("rst_ResVld", ResVld, 0);
    check("rst_Err", Err, 0);

    // Basic add 3 + 4 with latency check
    press(4'd3);
    check("basic_A", A, 3);
    key_down(4'd4);
    check("basic_B", B, 4);
    check("basic_vld_n1", ResVld, 0);
    key_up();
    check("basic_vld_n2", ResVld, 1);
    check("basic_Res", Res, 7);

    // Carry 9 + 9, then restart with 2
    key_down(4'd9);
    check("carry_restart_vld", ResVld, 0);
    key_up();
    press(4'd9);
    check("carry_Res", Res, 18);
    check("carry_vld", ResVld, 1);
    key_down(4'd2);
    check("next_vld_drop", ResVld, 0);
    check("next_A", A, 2);
    check("next_B", B, 0);
    check("next_Res_hold", Res, 18);
    key_up();
    press(4'd3);
    check("next_Res", Res, 5);

    // Invalid key in S_A
    do_reset();
    press(4'd12);
    check("inv_Err", Err, 1);
    check("inv_A", A, 0);
    press(4'd5);
    check("inv_clear_Err", Err, 0);
    check("inv_A5", A, 5);
    press(4'd7);
    check("inv_Res", Res, 12);
    press(4'd15);
    check("inv_show_Err", Err, 1);
    check("inv_show_vld", ResVld, 1);
    check("inv_show_A", A, 5);

    // Held key gives a single press
    do_reset();
    Key    = 4'd6;
    KeyVld = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("held_A", A, 6);
    check("held_B", B, 0);
    Key = 4'd8;
    tick();
    check("held_B2", B, 0);
    key_up();
    press(4'd1);
    check("held_B1", B, 1);
    check("held_Res", Res, 7);

    // Key already held at reset release
    Rst    = 1'b0;
    Key    = 4'd4;
    KeyVld = 1'b1;
    tick();
    Rst = 1'b1;
    tick();
    tick();
    tick();
    check("hold_rst_A", A, 0);
    key_up();
    press(4'd2);
    check("hold_rst_A2", A, 2);

    // Clear with simultaneous press
    do_reset();
    press(4'd7);
    check("clr_pre_A", A, 7);
    Key    = 4'd3;
    KeyVld = 1'b1;
    Clr    = 1'b1;
    tick();
    Clr = 1'b0;
    check("clr_A", A, 0);
    check("clr_B", B, 0);
    key_up();
    press(4'd8);
    check("clr_A8", A, 8);
    press(4'd1);
    check("clr_Res", Res, 9);
    Clr = 1'b1;
    tick();
    Clr = 1'b0;
    check("clr_show_Res", Res, 0);
    check("clr_show_vld", ResVld, 0);

    // Reset during S_ADD
    do_reset();
    press(4'd4);
    key_down(4'd5);
    Rst    = 1'b0;
    KeyVld = 1'b0;
    tick();
    check("radd_Res", Res, 0);
    check("radd_vld", ResVld, 0);
    check("radd_Err", Err, 0);
    check("radd_A", A, 0);
    Rst = 1'b1;
    tick();
    press(4'd1);
    press(4'd1);
    check("radd_after_Res", Res, 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
